insn_fetch: RTL and testbench

//  Instruction fetch unit: the requester side of insn_mem. Holds the PC, drives the word index
//  to insn_mem, captures the combinational read into an IF/ID output register, and hands it

---
 rtl/insn_fetch_pkg.sv | 18 +
 rtl/insn_fetch.sv | 104 ++++++++++
 tb/tb_insn_fetch.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/insn_fetch_pkg.sv
// insn_fetch_pkg: shared definitions for the instruction fetch unit.
//   FETCH_ADDR_W  default word-index width (insn_mem depth 1024)
//   ECALL_INSN    sentinel word that stops fetch
//   NOP_INSN      canonical RISC-V NOP (addi x0,x0,0)
//   fetch_state_t fetch FSM states (codes kept from the original defines)
package insn_fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 10;
    localparam logic [31:0] ECALL_INSN   = 32'h0000_0073;
    localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/insn_fetch.sv
// insn_fetch: requester side of insn_mem. Holds the PC, presents the word
// index to insn_mem, captures the combinational read into the IF/ID register
// and hands it to decode over a valid/ready handshake. Supports stall,
// redirect-with-flush and halt on a sentinel instruction.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start           leave IDLE/HALT and fetch from RESET_PC
//   redirect_valid  taken branch/jump this cycle; redirect_pc is the target
//   pc_out          registered word index to insn_mem
//   insn_in         insn_mem read data for pc_out (same cycle)
//   fetch_valid/fetch_ready/fetch_insn/fetch_pc  IF/ID handshake and payload
//   halted          fetch stopped on HALT_INSN
module insn_fetch
    import insn_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W    = FETCH_ADDR_W,
    parameter int unsigned RESET_PC  = 0,
    parameter logic [31:0] HALT_INSN = ECALL_INSN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc_out,
    input  logic [31:0]       insn_in,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [31:0]       fetch_insn,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic              valid_n;
    logic [31:0]       insn_n;
    logic [ADDR_W-1:0] fpc_n;
    logic              adv;

    // The output slot can take a new word when it is empty or being drained.
    assign adv = (state == ST_RUN) && (!fetch_valid || fetch_ready);

    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        valid_n = fetch_valid;
        insn_n  = fetch_insn;
        fpc_n   = fetch_pc;
        case (state)
            ST_RUN: begin
                if (redirect_valid) begin
                    // Flush wins even over a completing handshake: the held
                    // word is on the wrong path.
                    pc_n    = redirect_pc;
                    valid_n = 1'b0;
                end else if (adv) begin
                    insn_n  = insn_in;
                    fpc_n   = pc_q;
                    valid_n = 1'b1;
                    if (insn_in == HALT_INSN) begin
                        // pc_out stays on the halt word.
                        state_n = ST_HALT;
                    end else begin
                        pc_n = pc_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                // IDLE and HALT: no captures, redirects ignored; a pending
                // word still drains through the handshake.
                if (start) begin
                    state_n = ST_RUN;
                    pc_n    = RESET_PC_W;
                    valid_n = 1'b0;
                end else if (fetch_valid && fetch_ready) begin
                    valid_n = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc_q        <= RESET_PC_W;
            fetch_valid <= 1'b0;
            fetch_insn  <= '0;
            fetch_pc    <= '0;
        end else begin
            state       <= state_n;
            pc_q        <= pc_n;
            fetch_valid <= valid_n;
            fetch_insn  <= insn_n;
            fetch_pc    <= fpc_n;
        end
    end

    assign pc_out = pc_q;
    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: a word-array memory stands in for insn_mem, a
// cycle-level behavioural model predicts every output, and directed
// scenarios pin the model with hand-computed values.
module tb_insn_fetch;

    localparam logic [31:0] HALT = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic [9:0]  pc_out;
    logic [31:0] insn_in;
    logic        fetch_valid;
    logic        fetch_ready = 1'b0;
    logic [31:0] fetch_insn;
    logic [9:0]  fetch_pc;
    logic        halted;

    logic [31:0] mem [1024];

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    assign insn_in = mem[pc_out];

    insn_fetch #(
        .ADDR_W   (10),
        .RESET_PC (0),
        .HALT_INSN(32'h0000_0073)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .pc_out        (pc_out),
        .insn_in       (insn_in),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .fetch_insn    (fetch_insn),
        .fetch_pc      (fetch_pc),
        .halted        (halted)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_RUN, M_HALT} mmode_t;
    mmode_t      m_mode;
    int          m_pc;
    bit          m_valid;
    logic [31:0] m_insn;
    int          m_fpc;

    always @(posedge clk) begin
        if (rst) begin
            m_mode  <= M_IDLE;
            m_pc    <= 0;
            m_valid <= 1'b0;
            m_insn  <= '0;
            m_fpc   <= 0;
        end else if (m_mode == M_RUN) begin
            if (redirect_valid) begin
                m_pc    <= int'(redirect_pc);
                m_valid <= 1'b0;
            end else if (!m_valid || fetch_ready) begin
                m_insn  <= mem[m_pc];
                m_fpc   <= m_pc;
                m_valid <= 1'b1;
                if (mem[m_pc] == HALT) m_mode <= M_HALT;
                else m_pc <= (m_pc + 1) % 1024;
            end
        end else begin
            if (start) begin
                m_mode  <= M_RUN;
                m_pc    <= 0;
                m_valid <= 1'b0;
            end else if (m_valid && fetch_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m_pc_out", {22'b0, pc_out}, m_pc);
            chk("m_valid", {31'b0, fetch_valid}, {31'b0, m_valid});
            chk("m_fetch_pc", {22'b0, fetch_pc}, m_fpc);
            chk("m_fetch_insn", fetch_insn, m_insn);
            chk("m_halted", {31'b0, halted}, {31'b0, m_mode == M_HALT});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic expect_out(input string nm, input bit v, input int fpc,
                              input logic [31:0] ins, input int pco, input bit h);
        chk({nm, "_valid"}, {31'b0, fetch_valid}, {31'b0, v});
        if (v) begin
            chk({nm, "_fpc"}, {22'b0, fetch_pc}, fpc);
            chk({nm, "_insn"}, fetch_insn, ins);
        end
        chk({nm, "_pc_out"}, {22'b0, pc_out}, pco);
        chk({nm, "_halted"}, {31'b0, halted}, {31'b0, h});
    endtask

    task automatic do_reset_start();
        rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; fetch_ready = 1'b1;
        step(2);
        rst = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0010_80B3 + 32'(i) * 32'h0000_1000;

        // 1: reset state, then start and stream four words
        @(negedge clk);
        rst = 1'b1; fetch_ready = 1'b1;
        step(2);
        cmp_on = 1'b1;
        rst = 1'b0;
        chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
        chk("rst_insn", fetch_insn, 32'd0);
        chk("rst_fpc", {22'b0, fetch_pc}, 32'd0);
        chk("rst_pc_out", {22'b0, pc_out}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        expect_out("start", 1'b0, 0, '0, 0, 1'b0);
        step(1); expect_out("f0", 1'b1, 0, 32'h0010_80B3, 1, 1'b0);
        step(1); expect_out("f1", 1'b1, 1, 32'h0010_90B3, 2, 1'b0);
        step(1); expect_out("f2", 1'b1, 2, 32'h0010_A0B3, 3, 1'b0);
        step(1); expect_out("f3", 1'b1, 3, 32'h0010_B0B3, 4, 1'b0);

        // 2: stall while word 1 is presented
        do_reset_start();
        step(2);
        expect_out("pre_stall", 1'b1, 1, 32'h0010_90B3, 2, 1'b0);
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            expect_out("stall", 1'b1, 1, 32'h0010_90B3, 2, 1'b0);
        end
        fetch_ready = 1'b1;
        step(1); expect_out("release2", 1'b1, 2, 32'h0010_A0B3, 3, 1'b0);
        step(1); expect_out("release3", 1'b1, 3, 32'h0010_B0B3, 4, 1'b0);

        // 3: redirect with handshake open, then redirect during a stall
        redirect_valid = 1'b1; redirect_pc = 10'd100;
        step(1);
        redirect_valid = 1'b0;
        expect_out("redir_flush", 1'b0, 0, '0, 100, 1'b0);
        step(1); expect_out("redir_tgt", 1'b1, 100, 32'h0016_C0B3, 101, 1'b0);
        fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'd200;
        step(1);
        redirect_valid = 1'b0; fetch_ready = 1'b1;
        expect_out("redir_stall_flush", 1'b0, 0, '0, 200, 1'b0);
        step(1); expect_out("redir_stall_tgt", 1'b1, 200, 32'h001D_00B3, 201, 1'b0);

        // 4: halt on sentinel at word 5, then restart
        mem[5] = HALT;
        do_reset_start();
        step(5);
        expect_out("pre_halt", 1'b1, 4, 32'h0010_C0B3, 5, 1'b0);
        step(1); expect_out("halt_cap", 1'b1, 5, HALT, 5, 1'b1);
        step(1); expect_out("halt_drain", 1'b0, 0, '0, 5, 1'b1);
        chk("halt_fpc_kept", {22'b0, fetch_pc}, 32'd5);
        redirect_valid = 1'b1; redirect_pc = 10'd33;
        step(2); expect_out("halt_idle", 1'b0, 0, '0, 5, 1'b1);
        redirect_valid = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        expect_out("restart", 1'b0, 0, '0, 0, 1'b0);
        step(1); expect_out("restart_f0", 1'b1, 0, 32'h0010_80B3, 1, 1'b0);
        mem[5] = 32'h0010_80B3 + 32'd5 * 32'h0000_1000;

        // 5: wrap at the top of the index space
        redirect_valid = 1'b1; redirect_pc = 10'd1023;
        step(1);
        redirect_valid = 1'b0;
        expect_out("wrap_redir", 1'b0, 0, '0, 1023, 1'b0);
        step(1); expect_out("wrap_1023", 1'b1, 1023, 32'h0050_70B3, 0, 1'b0);
        step(1); expect_out("wrap_0", 1'b1, 0, 32'h0010_80B3, 1, 1'b0);
        step(1); expect_out("wrap_1", 1'b1, 1, 32'h0010_90B3, 2, 1'b0);

        // 6: reset while stalled, then idle behaviour
        fetch_ready = 1'b0;
        step(1);
        expect_out("pre_rst", 1'b1, 1, 32'h0010_90B3, 2, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_out("rst_stall", 1'b0, 0, '0, 0, 1'b0);
        chk("rst_stall_insn", fetch_insn, 32'd0);
        fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'd77;
        step(3);
        redirect_valid = 1'b0;
        expect_out("idle_hold", 1'b0, 0, '0, 0, 1'b0);

        // mixed traffic against the model, with a sentinel in range
        mem[600] = HALT;
        start = 1'b1;
        step(1);
        for (int i = 0; i < 400; i++) begin
            start          = ($urandom_range(0, 31) == 0);
            fetch_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 10'd598 : 10'($urandom_range(0, 1023));
            step(1);
        end
        start = 1'b0; redirect_valid = 1'b0;
        step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
